// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard sources into
// per-stage enables/flushes, times out memory waits, and keeps event counters.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ld_use_stall,
    input  logic             i_br_taken_execute,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ack,
    input  logic             i_cnt_clr,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_id_ex_en,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_flush,
    output logic             o_mem_err,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_ldstall_cnt,
    output logic [CNT_W-1:0] o_memwait_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ERR  = 2'b10
    } state_t;

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_next;

    logic mem_stall;
    logic rule_freeze;
    logic rule_branch;
    logic rule_lduse;

    assign mem_stall   = i_dmem_req & ~i_dmem_ack;
    assign rule_freeze = (state == MEM_ERR) | mem_stall;
    assign rule_branch = ~rule_freeze & i_br_taken_execute;
    assign rule_lduse  = ~rule_freeze & ~i_br_taken_execute & i_ld_use_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ack || !i_dmem_req) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_next    = MEM_ERR;
                    wait_cnt_next = '0;
                end else begin
                    wait_cnt_next = wait_cnt + WAIT_ONE;
                end
            end
            MEM_ERR: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    always_comb begin
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_id_ex_en     = 1'b1;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_flush = 1'b0;
        o_mem_err      = 1'b0;
        if (i_reset) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_ex_mem_flush = 1'b1;
        end else if (rule_freeze) begin
            // A timed-out access still retires, but as a bubble.
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = (state == MEM_ERR);
            o_ex_mem_flush = (state == MEM_ERR);
            o_mem_err      = (state == MEM_ERR);
        end else if (rule_branch) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
        end else if (rule_lduse) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_flush  = 1'b1;
        end
    end

    assign o_state = state;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_cnt_clr) begin
            o_ldstall_cnt <= '0;
            o_memwait_cnt <= '0;
            o_flush_cnt   <= '0;
        end else begin
            if (rule_lduse && (o_ldstall_cnt != '1)) begin
                o_ldstall_cnt <= o_ldstall_cnt + CNT_ONE;
            end
            if (rule_freeze && (o_memwait_cnt != '1)) begin
                o_memwait_cnt <= o_memwait_cnt + CNT_ONE;
            end
            if (rule_branch && (o_flush_cnt != '1)) begin
                o_flush_cnt <= o_flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized bench for pipeline_ctrl against a cycle-counting reference model
// of the hazard priority rules, memory timeout and saturating counters.
module tb_pipeline_ctrl;

    localparam int unsigned TMO = 4;
    localparam int unsigned CW  = 4;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, ld, br, req, ack, clr;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
    logic [1:0]    state;
    logic [CW-1:0] ldstall_cnt, memwait_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: frozen cycles seen so far in the current wait, and
    // whether the present cycle is the error cycle.
    int m_frozen = 0;
    bit m_err    = 1'b0;
    int m_ld = 0, m_mw = 0, m_fl = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_ld_use_stall     (ld),
        .i_br_taken_execute (br),
        .i_dmem_req         (req),
        .i_dmem_ack         (ack),
        .i_cnt_clr          (clr),
        .o_pc_en            (pc_en),
        .o_if_id_en         (if_id_en),
        .o_id_ex_en         (id_ex_en),
        .o_ex_mem_en        (ex_mem_en),
        .o_mem_wb_en        (mem_wb_en),
        .o_if_id_flush      (if_id_flush),
        .o_id_ex_flush      (id_ex_flush),
        .o_ex_mem_flush     (ex_mem_flush),
        .o_mem_err          (mem_err),
        .o_state            (state),
        .o_ldstall_cnt      (ldstall_cnt),
        .o_memwait_cnt      (memwait_cnt),
        .o_flush_cnt        (flush_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    // One clock cycle: drive inputs, check against the model, then advance the model.
    task automatic cycle(input bit r, input bit l, input bit b, input bit q,
                         input bit a, input bit c);
        bit freeze, do_br, do_ld;
        bit [7:0] exp_v;
        @(negedge clk);
        rst = r; ld = l; br = b; req = q; ack = a; clr = c;
        #1;
        freeze = m_err || (q && !a);
        do_br  = !freeze && b;
        do_ld  = !freeze && !b && l;
        // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_f, id_ex_f, ex_mem_f}
        if (r)           exp_v = 8'b00000_111;
        else if (m_err)  exp_v = 8'b00001_001;
        else if (freeze) exp_v = 8'b00000_000;
        else if (do_br)  exp_v = 8'b11111_110;
        else if (do_ld)  exp_v = 8'b00111_010;
        else             exp_v = 8'b11111_000;
        check("ctrl", int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                            if_id_flush, id_ex_flush, ex_mem_flush}), int'(exp_v));
        check("mem_err", int'(mem_err), int'(m_err && !r));
        check("state", int'(state), m_err ? 2 : (m_frozen > 0 ? 1 : 0));
        check("ldstall_cnt", int'(ldstall_cnt), m_ld);
        check("memwait_cnt", int'(memwait_cnt), m_mw);
        check("flush_cnt", int'(flush_cnt), m_fl);

        if (r || c) begin
            m_ld = 0; m_mw = 0; m_fl = 0;
        end else begin
            if (do_ld)  m_ld = sat_inc(m_ld);
            if (freeze) m_mw = sat_inc(m_mw);
            if (do_br)  m_fl = sat_inc(m_fl);
        end
        if (r || m_err) begin
            m_err = 1'b0; m_frozen = 0;
        end else if (q && !a) begin
            if (m_frozen + 1 == TMO) begin
                m_err = 1'b1; m_frozen = 0;
            end else begin
                m_frozen++;
            end
        end else begin
            m_frozen = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; ld = 1'b0; br = 1'b0; req = 1'b0; ack = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        cycle(1, 0, 0, 0, 0, 0);
        idle(1);

        // Single load-use stall, then branch colliding with load-use
        cycle(0, 1, 0, 0, 0, 0);
        idle(1);
        cycle(0, 1, 1, 0, 0, 0);
        idle(1);

        // Memory wait acked after three frozen cycles, branch held throughout
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0);
        cycle(0, 0, 1, 1, 1, 0);
        idle(1);

        // Timeout: four frozen cycles, error cycle, then a fresh wait
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 1, 0, 0);
        idle(1);

        // Ack offered during the error cycle must be ignored
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 1, 1, 1, 1, 0);
        idle(1);

        // Counter saturation and clear
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        idle(1);

        // Reset in the middle of a wait
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 0, 0);
        cycle(1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                  ($urandom_range(4) == 0), ($urandom_range(1) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(39) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
